// File: rtl/rivyera_core_bridge_pkg.sv
// Shared widths, command codes, CTRL/STATUS layout and request-buffer types
// for the RIVYERA register bridge.
package rivyera_core_bridge_pkg;

    localparam int C_LENGTH_CMD      = 2;
    localparam int C_LENGTH_ADDR_REG = 16;
    localparam int C_LENGTH_DATA     = 64;
    localparam int C_LENGTH_SLOT     = 4;
    localparam int C_LENGTH_FPGA     = 4;

    localparam logic [C_LENGTH_CMD-1:0] CMD_RD = 2'd1;
    localparam logic [C_LENGTH_CMD-1:0] CMD_WR = 2'd2;

    // CTRL/STATUS sit directly above the output registers
    localparam int CTRL_OFS   = 0;
    localparam int STATUS_OFS = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 3;

    typedef struct packed {
        logic [C_LENGTH_SLOT-1:0]     slot;
        logic [C_LENGTH_FPGA-1:0]     fpga;
        logic [C_LENGTH_ADDR_REG-1:0] src_reg;
        logic [C_LENGTH_ADDR_REG-1:0] tgt_reg;
    } rq_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } ctrl_state_e;

    function automatic logic [C_LENGTH_DATA-1:0] status_word(
        input logic err,
        input logic done,
        input logic busy
    );
        logic [C_LENGTH_DATA-1:0] w;
        w = '0;
        w[STAT_ERR]  = err;
        w[STAT_DONE] = done;
        w[STAT_BUSY] = busy;
        return w;
    endfunction

endpackage

// File: rtl/rivyera_rq_fifo.sv
// Pending read-request buffer: synchronous FIFO with count-based
// full/empty and a first-word-fall-through head.
module rivyera_rq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             api_clk_in,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge api_clk_in) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge api_clk_in or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rivyera_core_bridge.sv
// Register-mapped bridge between the RIVYERA API FIFOs and one user core.
// Define RIVYERA_BRIDGE_AUTOSTART_EN to also start on a write to reg N_IN-1.
module rivyera_core_bridge
    import rivyera_core_bridge_pkg::*;
#(
    parameter int N_IN     = 6,
    parameter int N_OUT    = 2,
    parameter int RQ_DEPTH = 4,
    parameter int CNT_W    = 32
) (
    input  logic                           api_clk_in,
    input  logic                           api_rst_in,
    input  logic                           api_i_empty_in,
    output logic                           api_i_rd_en_out,
    input  logic [C_LENGTH_CMD-1:0]        api_i_tgt_cmd_in,
    input  logic [C_LENGTH_ADDR_REG-1:0]   api_i_tgt_reg_in,
    input  logic [C_LENGTH_DATA-1:0]       api_i_data_in,
    input  logic [C_LENGTH_SLOT-1:0]       api_i_src_slot_in,
    input  logic [C_LENGTH_FPGA-1:0]       api_i_src_fpga_in,
    input  logic [C_LENGTH_ADDR_REG-1:0]   api_i_src_reg_in,
    input  logic                           api_o_rfd_in,
    output logic                           api_o_wr_en_out,
    output logic [C_LENGTH_SLOT-1:0]       api_o_tgt_slot_out,
    output logic [C_LENGTH_FPGA-1:0]       api_o_tgt_fpga_out,
    output logic [C_LENGTH_ADDR_REG-1:0]   api_o_tgt_reg_out,
    output logic [C_LENGTH_ADDR_REG-1:0]   api_o_src_reg_out,
    output logic [C_LENGTH_DATA-1:0]       api_o_data_out,
    output logic [N_IN*C_LENGTH_DATA-1:0]  core_in_out,
    input  logic [N_OUT*C_LENGTH_DATA-1:0] core_out_in,
    output logic                           core_start_out,
    input  logic                           core_done_in
);

    localparam int AW = C_LENGTH_ADDR_REG;
    localparam int DW = C_LENGTH_DATA;
    localparam logic [AW-1:0] ADDR_CTRL = AW'(N_IN + N_OUT + CTRL_OFS);
    localparam logic [AW-1:0] ADDR_STAT = AW'(N_IN + N_OUT + STATUS_OFS);

    logic [DW-1:0] in_regs [N_IN];
    logic          pop_hold_q;
    logic          pop;
    logic          wr_pop;
    logic          rd_pop;
    logic          start_req;
    logic          rq_full;
    logic          rq_empty;
    rq_t           rq_wdata;
    rq_t           rq_head;
    logic          resp_fire;
    logic          stat_clr;
    logic [DW-1:0] rd_data;
    ctrl_state_e   state;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [CNT_W-1:0] cnt_q;

    // pop_hold_q resets high so rd_en stays low while reset is asserted
    assign pop             = !api_i_empty_in && !pop_hold_q && !rq_full;
    assign api_i_rd_en_out = pop;
    assign wr_pop          = pop && (api_i_tgt_cmd_in == CMD_WR);
    assign rd_pop          = pop && (api_i_tgt_cmd_in == CMD_RD);

`ifdef RIVYERA_BRIDGE_AUTOSTART_EN
    assign start_req = wr_pop &&
                       (((api_i_tgt_reg_in == ADDR_CTRL) && api_i_data_in[0]) ||
                        (api_i_tgt_reg_in == AW'(N_IN - 1)));
`else
    assign start_req = wr_pop &&
                       (api_i_tgt_reg_in == ADDR_CTRL) && api_i_data_in[0];
`endif

    always_ff @(posedge api_clk_in or posedge api_rst_in) begin
        if (api_rst_in) begin
            pop_hold_q <= 1'b1;
        end else begin
            pop_hold_q <= pop;
        end
    end

    always_ff @(posedge api_clk_in or posedge api_rst_in) begin
        if (api_rst_in) begin
            for (int i = 0; i < N_IN; i++) begin
                in_regs[i] <= '0;
            end
        end else if (wr_pop) begin
            for (int i = 0; i < N_IN; i++) begin
                if (api_i_tgt_reg_in == AW'(i)) begin
                    in_regs[i] <= api_i_data_in;
                end
            end
        end
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_core_in
        assign core_in_out[g*DW +: DW] = in_regs[g];
    end

    assign rq_wdata.slot    = api_i_src_slot_in;
    assign rq_wdata.fpga    = api_i_src_fpga_in;
    assign rq_wdata.src_reg = api_i_src_reg_in;
    assign rq_wdata.tgt_reg = api_i_tgt_reg_in;

    rivyera_rq_fifo #(
        .DEPTH (RQ_DEPTH),
        .WIDTH ($bits(rq_t))
    ) u_rq_fifo (
        .api_clk_in (api_clk_in),
        .reset      (api_rst_in),
        .wr_en      (rd_pop),
        .wr_data    (rq_wdata),
        .rd_en      (resp_fire),
        .rd_data    (rq_head),
        .full       (rq_full),
        .empty      (rq_empty)
    );

    assign resp_fire = !rq_empty && api_o_rfd_in;
    assign stat_clr  = resp_fire && (rq_head.tgt_reg == ADDR_STAT);

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (rq_head.tgt_reg == AW'(i)) begin
                rd_data = in_regs[i];
            end
        end
        for (int i = 0; i < N_OUT; i++) begin
            if (rq_head.tgt_reg == AW'(N_IN + i)) begin
                rd_data = core_out_in[i*DW +: DW];
            end
        end
        if (rq_head.tgt_reg == ADDR_CTRL) begin
            rd_data = DW'(cnt_q);
        end
        if (rq_head.tgt_reg == ADDR_STAT) begin
            rd_data = status_word(err_q, done_q, busy_q);
        end
    end

    always_ff @(posedge api_clk_in or posedge api_rst_in) begin
        if (api_rst_in) begin
            api_o_wr_en_out    <= 1'b0;
            api_o_tgt_slot_out <= '0;
            api_o_tgt_fpga_out <= '0;
            api_o_tgt_reg_out  <= '0;
            api_o_src_reg_out  <= '0;
            api_o_data_out     <= '0;
        end else begin
            api_o_wr_en_out <= resp_fire;
            if (resp_fire) begin
                api_o_tgt_slot_out <= rq_head.slot;
                api_o_tgt_fpga_out <= rq_head.fpga;
                api_o_tgt_reg_out  <= rq_head.src_reg;
                api_o_src_reg_out  <= rq_head.tgt_reg;
                api_o_data_out     <= rd_data;
            end
        end
    end

    // a new err event outranks a STATUS read clearing it in the same cycle
    always_ff @(posedge api_clk_in or posedge api_rst_in) begin
        if (api_rst_in) begin
            state          <= ST_IDLE;
            core_start_out <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            cnt_q          <= '0;
        end else begin
            core_start_out <= 1'b0;
            if (stat_clr) begin
                err_q <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state          <= ST_RUN;
                        core_start_out <= 1'b1;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        cnt_q          <= '0;
                    end
                end
                ST_RUN: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (start_req) begin
                        err_q <= 1'b1;
                    end
                    if (core_done_in) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rivyera_core_bridge.sv
// Self-checking bench for rivyera_core_bridge: table vectors, hand sequences
// for the run handshake and backpressure, and randomized register traffic.
module tb_rivyera_core_bridge;
    import rivyera_core_bridge_pkg::*;

    localparam int N_IN     = 6;
    localparam int N_OUT    = 2;
    localparam int RQ_DEPTH = 4;
    localparam int CNT_W    = 32;
    localparam int AW       = C_LENGTH_ADDR_REG;
    localparam int DW       = C_LENGTH_DATA;
    localparam int A_CTRL   = N_IN + N_OUT;
    localparam int A_STAT   = N_IN + N_OUT + 1;

    logic                     clk;
    logic                     rst;
    logic                     api_i_empty_in;
    logic                     api_i_rd_en_out;
    logic [C_LENGTH_CMD-1:0]  api_i_tgt_cmd_in;
    logic [AW-1:0]            api_i_tgt_reg_in;
    logic [DW-1:0]            api_i_data_in;
    logic [C_LENGTH_SLOT-1:0] api_i_src_slot_in;
    logic [C_LENGTH_FPGA-1:0] api_i_src_fpga_in;
    logic [AW-1:0]            api_i_src_reg_in;
    logic                     api_o_rfd_in;
    logic                     api_o_wr_en_out;
    logic [C_LENGTH_SLOT-1:0] api_o_tgt_slot_out;
    logic [C_LENGTH_FPGA-1:0] api_o_tgt_fpga_out;
    logic [AW-1:0]            api_o_tgt_reg_out;
    logic [AW-1:0]            api_o_src_reg_out;
    logic [DW-1:0]            api_o_data_out;
    logic [N_IN*DW-1:0]       core_in_out;
    logic [N_OUT*DW-1:0]      core_out_in;
    logic                     core_start_out;
    logic                     core_done_in;

    rivyera_core_bridge #(
        .N_IN     (N_IN),
        .N_OUT    (N_OUT),
        .RQ_DEPTH (RQ_DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .api_clk_in         (clk),
        .api_rst_in         (rst),
        .api_i_empty_in     (api_i_empty_in),
        .api_i_rd_en_out    (api_i_rd_en_out),
        .api_i_tgt_cmd_in   (api_i_tgt_cmd_in),
        .api_i_tgt_reg_in   (api_i_tgt_reg_in),
        .api_i_data_in      (api_i_data_in),
        .api_i_src_slot_in  (api_i_src_slot_in),
        .api_i_src_fpga_in  (api_i_src_fpga_in),
        .api_i_src_reg_in   (api_i_src_reg_in),
        .api_o_rfd_in       (api_o_rfd_in),
        .api_o_wr_en_out    (api_o_wr_en_out),
        .api_o_tgt_slot_out (api_o_tgt_slot_out),
        .api_o_tgt_fpga_out (api_o_tgt_fpga_out),
        .api_o_tgt_reg_out  (api_o_tgt_reg_out),
        .api_o_src_reg_out  (api_o_src_reg_out),
        .api_o_data_out     (api_o_data_out),
        .core_in_out        (core_in_out),
        .core_out_in        (core_out_in),
        .core_start_out     (core_start_out),
        .core_done_in       (core_done_in)
    );

    typedef struct {
        logic [C_LENGTH_CMD-1:0]  cmd;
        logic [AW-1:0]            tgt;
        logic [DW-1:0]            data;
        logic [C_LENGTH_SLOT-1:0] slot;
        logic [C_LENGTH_FPGA-1:0] fpga;
        logic [AW-1:0]            src;
    } hcmd_t;

    typedef struct {
        logic [C_LENGTH_SLOT-1:0] slot;
        logic [C_LENGTH_FPGA-1:0] fpga;
        logic [AW-1:0]            src;
        logic [AW-1:0]            tgt;
        logic [DW-1:0]            lo;
        logic [DW-1:0]            hi;
        string                    name;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            do_wr;
        logic [DW-1:0] exp;
    } vec_t;

    hcmd_t         in_q[$];
    exp_t          exp_q[$];
    logic [DW-1:0] in_model [N_IN];
    int            vec_cnt;
    int            fail_cnt;
    int            cyc;
    int            n_pops;
    int            n_resp;
    int            n_starts;
    int            start_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && api_i_rd_en_out && in_q.size() > 0) begin
            void'(in_q.pop_front());
            n_pops = n_pops + 1;
        end
    end

    // host FIFO model: first-word-fall-through head, updated off the edge
    always @(negedge clk) begin
        if (in_q.size() == 0) begin
            api_i_empty_in    = 1'b1;
            api_i_tgt_cmd_in  = '0;
            api_i_tgt_reg_in  = '0;
            api_i_data_in     = '0;
            api_i_src_slot_in = '0;
            api_i_src_fpga_in = '0;
            api_i_src_reg_in  = '0;
        end else begin
            api_i_empty_in    = 1'b0;
            api_i_tgt_cmd_in  = in_q[0].cmd;
            api_i_tgt_reg_in  = in_q[0].tgt;
            api_i_data_in     = in_q[0].data;
            api_i_src_slot_in = in_q[0].slot;
            api_i_src_fpga_in = in_q[0].fpga;
            api_i_src_reg_in  = in_q[0].src;
        end
    end

    always @(negedge clk) begin
        if (!rst && core_start_out) begin
            n_starts  = n_starts + 1;
            start_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && api_o_wr_en_out) begin
            n_resp  = n_resp + 1;
            vec_cnt = vec_cnt + 1;
            if (exp_q.size() == 0) begin
                fail_cnt = fail_cnt + 1;
                $display("FAIL unexpected_resp reg=%h data=%h",
                         api_o_src_reg_out, api_o_data_out);
            end else begin
                e = exp_q.pop_front();
                if (api_o_tgt_slot_out !== e.slot ||
                    api_o_tgt_fpga_out !== e.fpga ||
                    api_o_tgt_reg_out !== e.src ||
                    api_o_src_reg_out !== e.tgt ||
                    api_o_data_out < e.lo || api_o_data_out > e.hi) begin
                    fail_cnt = fail_cnt + 1;
                    $display("FAIL %s got %h/%h/%h reg=%h data=%h exp %h/%h/%h reg=%h data=[%h..%h]",
                             e.name, api_o_tgt_slot_out, api_o_tgt_fpga_out,
                             api_o_tgt_reg_out, api_o_src_reg_out,
                             api_o_data_out, e.slot, e.fpga, e.src, e.tgt,
                             e.lo, e.hi);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        vec_cnt = vec_cnt + 1;
        if (got !== exp) begin
            fail_cnt = fail_cnt + 1;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic hcmd_t mk_cmd(input logic [C_LENGTH_CMD-1:0] c,
                                     input int a, input logic [DW-1:0] d);
        hcmd_t h;
        h.cmd  = c;
        h.tgt  = AW'(a);
        h.data = d;
        h.slot = C_LENGTH_SLOT'($urandom);
        h.fpga = C_LENGTH_FPGA'($urandom);
        h.src  = AW'($urandom);
        return h;
    endfunction

    task automatic host_write(input int a, input logic [DW-1:0] d);
        in_q.push_back(mk_cmd(CMD_WR, a, d));
        if (a < N_IN) in_model[a] = d;
    endtask

    task automatic host_read(input int a, input logic [DW-1:0] lo,
                             input logic [DW-1:0] hi, input string nm);
        hcmd_t h;
        exp_t  e;
        h = mk_cmd(CMD_RD, a, '0);
        in_q.push_back(h);
        e.slot = h.slot;
        e.fpga = h.fpga;
        e.src  = h.src;
        e.tgt  = h.tgt;
        e.lo   = lo;
        e.hi   = hi;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    function automatic logic [DW-1:0] model_read(input int a);
        if (a < N_IN) return in_model[a];
        if (a < N_IN + N_OUT) return core_out_in[(a - N_IN)*DW +: DW];
        return '0;
    endfunction

    function automatic int rand_addr(input bit for_write);
        int k;
        k = int'($urandom_range(0, 3));
        if (k < 2) return int'($urandom_range(0, for_write ? N_IN - 2 : N_IN - 1));
        if (k == 2) return N_IN + int'($urandom_range(0, N_OUT - 1));
        return int'($urandom_range(A_STAT + 1, 16'hFFFF));
    endfunction

    task automatic drain(input int maxc, input bit rnd);
        int n;
        n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < maxc) begin
            if (rnd) api_o_rfd_in = 1'($urandom_range(0, 1));
            tick(1);
            n++;
        end
        api_o_rfd_in = 1'b1;
        if (n >= maxc) begin
            vec_cnt  = vec_cnt + 1;
            fail_cnt = fail_cnt + 1;
            $display("FAIL drain_timeout pending_in=%0d pending_resp=%0d",
                     in_q.size(), exp_q.size());
            in_q.delete();
            exp_q.delete();
        end
        tick(2);
    endtask

    task automatic wait_start(input string nm);
        int n;
        n = 0;
        while (n_starts == 0 && n < 50) begin
            tick(1);
            n++;
        end
        if (n_starts == 0) begin
            vec_cnt  = vec_cnt + 1;
            fail_cnt = fail_cnt + 1;
            $display("FAIL %s start_timeout got=0 exp=1", nm);
        end
    endtask

    task automatic pulse_done();
        core_done_in = 1'b1;
        tick(1);
        core_done_in = 1'b0;
        tick(1);
    endtask

    vec_t tbl [9];

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int r0;
        int nw;
        int nr;
        int a;
        rst          = 1'b1;
        api_o_rfd_in = 1'b0;
        core_done_in = 1'b0;
        cyc = 0; n_pops = 0; n_resp = 0; n_starts = 0; start_cyc = 0;
        vec_cnt = 0; fail_cnt = 0;
        for (int i = 0; i < N_IN; i++) in_model[i] = '0;
        core_out_in = {$urandom, $urandom, $urandom, $urandom};
        tick(3);
        check("rst_ctl_outs", DW'({api_i_rd_en_out, api_o_wr_en_out, core_start_out,
              api_o_tgt_slot_out, api_o_tgt_fpga_out, api_o_tgt_reg_out,
              api_o_src_reg_out}), '0);
        check("rst_data_out", api_o_data_out, '0);
        rst = 1'b0;
        tick(2);
        check("post_rst_outs", DW'({api_i_rd_en_out, api_o_wr_en_out,
              core_start_out, |core_in_out}), '0);
        api_o_rfd_in = 1'b1;
        host_read(A_STAT, 0, 0, "rst_status");
        host_read(A_CTRL, 0, 0, "rst_cnt");
        drain(200, 0);

        tbl[0] = '{16'd3, 64'hDEADBEEF_01234567, 1'b1, 64'hDEADBEEF_01234567};
        tbl[1] = '{16'd0, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 64'hFFFFFFFF_FFFFFFFF};
        tbl[2] = '{16'd4, 64'h80000000_00000001, 1'b1, 64'h80000000_00000001};
        tbl[3] = '{16'd1, 64'h0,                 1'b1, 64'h0};
        tbl[4] = '{16'd6, 64'h12345678_9ABCDEF0, 1'b1, core_out_in[63:0]};
        tbl[5] = '{16'd7, 64'h0,                 1'b0, core_out_in[127:64]};
        tbl[6] = '{16'd10, 64'h55555555_55555555, 1'b1, 64'h0};
        tbl[7] = '{16'hFFFF, 64'hAAAAAAAA_AAAAAAAA, 1'b1, 64'h0};
        tbl[8] = '{16'd3, 64'h0,                 1'b0, 64'hDEADBEEF_01234567};
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].do_wr) host_write(int'(tbl[i].addr), tbl[i].wdata);
            host_read(int'(tbl[i].addr), tbl[i].exp, tbl[i].exp,
                      $sformatf("tbl%0d", i));
        end
        drain(400, 0);
        check("core_in_reg3", core_in_out[3*DW +: DW], 64'hDEADBEEF_01234567);

        n_starts = 0;
        host_write(A_CTRL, 1);
        wait_start("run");
        host_read(A_STAT, 1, 1, "status_run");
        for (int n = 0; n < 100 && cyc < start_cyc + 19; n++) tick(1);
        pulse_done();
        host_read(A_STAT, 2, 2, "status_done");
        host_read(A_CTRL, 19, 21, "run_cnt");
        drain(200, 0);
        check("run_start_pulses", DW'(n_starts), 1);

        n_starts = 0;
        host_write(A_CTRL, 1);
        host_write(A_CTRL, 1);
        host_read(A_STAT, 9, 9, "status_err");
        host_read(A_STAT, 1, 1, "status_err_clr");
        drain(200, 0);
        check("busy_start_pulses", DW'(n_starts), 1);
        pulse_done();
        host_read(A_STAT, 2, 2, "status_idle");
        drain(200, 0);

        api_o_rfd_in = 1'b0;
        p0 = n_pops;
        r0 = n_resp;
        for (int i = 0; i < 6; i++) host_read(i, model_read(i), model_read(i),
                                              $sformatf("bp%0d", i));
        tick(30);
        check("bp_pops_stalled", DW'(n_pops - p0), RQ_DEPTH);
        check("bp_no_resp", DW'(n_resp - r0), 0);
        api_o_rfd_in = 1'b1;
        drain(200, 0);
        check("bp_all_resp", DW'(n_resp - r0), 6);

        for (int b = 0; b < 25; b++) begin
            nw = int'($urandom_range(1, 4));
            for (int k = 0; k < nw; k++) host_write(rand_addr(1'b1), {$urandom, $urandom});
            drain(200, 0);
            nr = int'($urandom_range(1, 6));
            for (int k = 0; k < nr; k++) begin
                a = rand_addr(1'b0);
                host_read(a, model_read(a), model_read(a), $sformatf("rnd%0d_%0d", b, k));
            end
            drain(400, 1);
        end

        n_starts = 0;
        host_write(N_IN - 1, 64'h5);
        drain(200, 0);
        tick(5);
`ifdef RIVYERA_BRIDGE_AUTOSTART_EN
        check("autostart_pulses", DW'(n_starts), 1);
        pulse_done();
`else
        check("autostart_pulses", DW'(n_starts), 0);
`endif

        n_starts = 0;
        host_write(A_CTRL, 1);
        wait_start("abort");
        api_o_rfd_in = 1'b0;
        in_q.push_back(mk_cmd(CMD_RD, 0, '0));
        in_q.push_back(mk_cmd(CMD_RD, 1, '0));
        tick(10);
        rst = 1'b1;
        tick(1);
        check("rst_mid_outs", DW'({core_start_out, api_o_wr_en_out,
              api_i_rd_en_out, |core_in_out}), '0);
        rst = 1'b0;
        in_q.delete();
        for (int i = 0; i < N_IN; i++) in_model[i] = '0;
        api_o_rfd_in = 1'b1;
        r0 = n_resp;
        tick(10);
        check("rst_discard", DW'(n_resp - r0), 0);
        host_read(A_STAT, 0, 0, "status_after_abort");
        host_read(0, 0, 0, "reg0_after_abort");
        drain(200, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/rivyera_core_bridge.md
Name: rivyera_core_bridge

Overview:
- Parametrised register-mapped bridge between the RIVYERA API input/output register FIFOs and one multi-cycle user core.
- Generalises the fixed 6-in/2-out AES wrapper to N_IN input and N_OUT output 64-bit registers.
- Adds a control/status register with a start/busy/done handshake, a queued read-request buffer so back-to-back reads are never dropped, and a busy-cycle counter.
- Instantiated in each user *_main top; the user core hangs off the core_* ports.

Parameters:
- N_IN, 6, number of host-writable input registers (1..32).
- N_OUT, 2, number of read-only output registers (1..32).
- RQ_DEPTH, 4, pending read-request buffer depth (power of 2, >=2).
- CNT_W, 32, width of the busy-cycle counter.

Ports:
- api_clk_in  in  1  single clock for all logic.
- api_rst_in  in  1  asynchronous active-high reset.
- api_i_empty_in  in  1  input FIFO empty; first-word-fall-through, so the head entry is valid while low.
- api_i_rd_en_out  out  1  pops the input FIFO head.
- api_i_tgt_cmd_in  in  `C_LENGTH_CMD  `CMD_RD or `CMD_WR.
- api_i_tgt_reg_in  in  `C_LENGTH_ADDR_REG  addressed register.
- api_i_data_in  in  `C_LENGTH_DATA  write data.
- api_i_src_slot_in / api_i_src_fpga_in / api_i_src_reg_in  in  slot/fpga/reg widths  requester return address.
- api_o_rfd_in  in  1  output FIFO ready-for-data.
- api_o_wr_en_out  out  1  output FIFO push.
- api_o_tgt_slot_out / api_o_tgt_fpga_out / api_o_tgt_reg_out  out  slot/fpga/reg widths  return address taken from the buffered request.
- api_o_src_reg_out  out  `C_LENGTH_ADDR_REG  register that was read.
- api_o_data_out  out  `C_LENGTH_DATA  read data.
- core_in_out  out  N_IN*`C_LENGTH_DATA  input registers concatenated; reg0 at the LSBs.
- core_out_in  in  N_OUT*`C_LENGTH_DATA  core results; out-reg0 at the LSBs.
- core_start_out  out  1  one-cycle start pulse.
- core_done_in  in  1  one-cycle completion pulse from the core.

Behaviour:
- Address map:
  - 0..N_IN-1: input registers, read/write.
  - N_IN..N_IN+N_OUT-1: output registers, read-only; the value returned is live core_out_in.
  - CTRL = N_IN+N_OUT: a write with data[0]=1 requests start. A read returns {32'b0 (upper), CNT}.
  - CTRL+1 = STATUS: read returns {60'b0, err, 1'b0, done, busy}.
  - Any other address: reads return 0; writes are ignored.
- Input side:
  - Pop when api_i_empty_in=0, api_i_rd_en_out was 0 last cycle, and the request buffer is not full (writes are also gated by a full buffer, to keep ordering simple).
  - api_i_rd_en_out is a one-cycle pulse, so at most one pop every 2 cycles.
  - The write or read enqueue takes effect in the pop cycle.
- Read buffer:
  - RQ_DEPTH-entry FIFO holding {src_slot, src_fpga, src_reg, tgt_reg}.
  - When the buffer is full, input pops stall and no request is lost.
- Response engine:
  - When the buffer is non-empty and api_o_rfd_in=1, pulse api_o_wr_en_out for one cycle.
  - Address and data outputs are registered in the same edge, taken from the buffer head.
  - Data is sampled at that edge. Latency from read pop to wr_en is 2 cycles when rfd is already high.
  - rfd low holds the head entry; wr_en stays 0.
- Control FSM (states IDLE, RUN):
  - IDLE + start write: core_start_out=1 for 1 cycle, busy=1, done=0, CNT=0, go to RUN.
  - RUN: CNT increments each cycle, saturating at all-ones.
  - RUN + core_done_in: busy=0, done=1, go to IDLE.
  - Start write while in RUN: ignored, err=1.
  - Reading STATUS clears err; in that cycle the read returns the pre-clear value.
  - core_done_in while in IDLE is ignored.
- Input-register writes while busy are accepted. Holding core_in_out stable during a run is the user core's responsibility.
- Simultaneous start write and core_done_in in RUN: done wins, start is flagged as err.
- Reset values:
  - All registers, CNT, busy, done and err are 0; FSM is in IDLE; the buffer is empty.
  - All outputs are 0.
  - Reset mid-run aborts the run: busy=0 immediately, and pending reads are discarded.

Optional Feature:
- Macro: RIVYERA_BRIDGE_AUTOSTART_EN.
- Defined: a write to input register N_IN-1 while IDLE also generates the start (same timing as a CTRL start). While RUN, the register is still written and err is set.
- Undefined: start only via a CTRL write.

Decomposition:
- Shared constants come from the existing SciEngines_API_constant.v: `CMD_RD, `CMD_WR, `C_LENGTH_*.
- CTRL/STATUS offset localparams and STATUS bit positions go in a new rivyera_bridge_defs.vh.
- One natural sub-module: rivyera_rq_fifo, a synchronous FIFO with count-based full/empty.

Test Plan:
- Reset defaults: reset, then release → all outputs 0, STATUS read returns 0x0.
- Register write/readback, N_IN=6: write reg3=0xDEADBEEF_01234567, then read reg3 → one wr_en with that data; tgt_* equals requester src_*; src_reg=3.
- Start/done handshake: write CTRL=1; core asserts done 20 cycles later → core_start_out pulses once; STATUS goes 0x1 then 0x2; CTRL read returns 20 (±1 per the edge definition).
- Busy start: write CTRL=1 twice with no done between → second start ignored; STATUS read shows err=1 (0x9); next STATUS read shows 0x1.
- Backpressure: 6 back-to-back reads with rfd=0 and RQ_DEPTH=4 → 4 requests queue, then pops stall; raise rfd → 6 ordered responses, none lost.
- AUTOSTART_EN defined: write reg5 in IDLE → start pulse follows. With the macro undefined, the same write gives no pulse.
